// File: rtl/digital_clock_pkg.sv
// digital_clock_pkg: shared segment patterns and digit-index types for the clock display path
package digital_clock_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int IDX_W = 3;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: BCD digit to {g,f,e,d,c,b,a} pattern, non-decimal codes shown as a dash
module bcd_to_7seg
  import digital_clock_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 6-digit multiplexed display driver with frame snapshot, colon and alarm flash; LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit
module seven_seg_scanner
  import digital_clock_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] h_i1,
  input  logic [3:0] h_i2,
  input  logic [3:0] m_i1,
  input  logic [3:0] m_i2,
  input  logic [3:0] s_i1,
  input  logic [3:0] s_i2,
  input  logic       alarm_i,
  output seg_t       seg_o,
  output logic       dp_o,
  output logic [5:0] an_o
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  logic [PW-1:0] presc;
  idx_t idx;
  logic [FW-1:0] frame_cnt;
  logic phase_on;
  logic [NUM_DIGITS-1:0][3:0] sh;
  logic sh_alarm;
  logic term, wrap, blank, lz, dp_d;
  logic [3:0] digit;
  seg_t pat, seg_d;
  logic [5:0] an_d;
  assign term = presc == PW'(SCAN_DIV - 1);
  assign wrap = term && idx == IDX_W'(NUM_DIGITS - 1);
  assign digit = sh[idx];
  bcd_to_7seg u_dec (.bcd(digit), .seg(pat));
  // The blanked first cycle of every slot hides ghosting while anodes switch.
  always_comb begin
    blank = presc == '0 || (sh_alarm && !phase_on);
`ifdef LEADING_ZERO_BLANK_EN
    lz = idx == '0 && sh[0] == '0;
`else
    lz = 1'b0;
`endif
    an_d = blank ? 6'h3F : ~(6'b1 << idx);
    seg_d = (blank || lz) ? SEG_BLANK : pat;
    dp_d = !blank && (idx == IDX_W'(1) || idx == IDX_W'(3)) && !sh[5][0];
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc <= '0;
      idx <= '0;
      frame_cnt <= '0;
      phase_on <= 1'b1;
      sh <= '0;
      sh_alarm <= 1'b0;
      an_o <= 6'h3F;
      seg_o <= SEG_BLANK;
      dp_o <= 1'b0;
    end else begin
      presc <= term ? '0 : presc + 1'b1;
      if (term) idx <= wrap ? '0 : idx + 1'b1;
      if (wrap) begin
        sh <= {s_i2, s_i1, m_i2, m_i1, h_i2, {2'b00, h_i1}};
        sh_alarm <= alarm_i;
        // A fresh alarm (or none) restarts the flash on a lit half-period.
        if (!alarm_i || !sh_alarm) begin
          frame_cnt <= '0;
          phase_on <= 1'b1;
        end else if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase_on <= !phase_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      an_o <= an_d;
      seg_o <= seg_d;
      dp_o <= dp_d;
    end
  end
endmodule
